gpio_debounce_irq: RTL and testbench

Per-pin debounce, edge/level detection and interrupt aggregation for the 32-pin GPIO bank.
Sits directly downstream of the pin synchronizer and consumes its already-synchronized input vector.
Produces the debounced pin values for the APB read path, plus sticky interrupt status and a single interrupt line.
All configuration comes from the APB register file as static levels; irq_clear is a one-cycle write-1-to-clear pulse.

---
 rtl/gpio_pkg.sv | 38 +++
 rtl/gpio_debounce_cell.sv | 48 ++++
 rtl/gpio_debounce_irq.sv | 67 ++++++
 tb/tb_gpio_debounce_irq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared defaults, encodings and the per-pin event helper for the GPIO
// debounce / interrupt block.
package gpio_pkg;

    localparam int N_PINS_DEF = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        IRQ_TYPE_LEVEL = 1'b0,
        IRQ_TYPE_EDGE  = 1'b1
    } irq_type_e;

    typedef enum logic {
        IRQ_POL_LOW  = 1'b0,
        IRQ_POL_HIGH = 1'b1
    } irq_pol_e;

    // Edge mode uses the db_q/db_prev transition (irq_both overrides polarity);
    // level mode looks only at the current debounced value.
    function automatic logic pin_event(
        input logic type_bit,
        input logic pol_bit,
        input logic both_bit,
        input logic db,
        input logic prev
    );
        logic rise;
        logic fall;
        rise = db & ~prev;
        fall = ~db & prev;
        if (type_bit == IRQ_TYPE_EDGE) begin
            if (both_bit) return rise | fall;
            return (pol_bit == IRQ_POL_HIGH) ? rise : fall;
        end
        return (pol_bit == IRQ_POL_HIGH) ? db : ~db;
    endfunction

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin's debounce counter and debounced value, with a bypass path that
// simply registers the synchronized input.
module gpio_debounce_cell
    import gpio_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             sync_in,
    input  logic             db_en,
    input  logic [CNT_W-1:0] threshold,
    output logic             db_out
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_db_q;
    logic [CNT_W-1:0] w_thr_m1;
    logic             w_diff;
    logic             w_commit;

    // A zero threshold behaves as one, so the compare limit never underflows.
    assign w_thr_m1 = (threshold == '0) ? '0 : threshold - CNT_W'(1);
    assign w_diff   = (sync_in != r_db_q);
    assign w_commit = w_diff && (r_cnt >= w_thr_m1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt  <= '0;
            r_db_q <= 1'b0;
        end else if (!db_en) begin
            r_db_q <= sync_in;
            r_cnt  <= '0;
        end else if (!w_diff) begin
            r_cnt  <= '0;
        end else if (w_commit) begin
            r_db_q <= sync_in;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign db_out = r_db_q;

endmodule

// File: rtl/gpio_debounce_irq.sv
// Per-pin debounce, edge/level event detection, sticky W1C interrupt status
// and single interrupt line for the GPIO bank.
module gpio_debounce_irq
    import gpio_pkg::*;
#(
    parameter int N_PINS = N_PINS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [N_PINS-1:0] sync_gpio_in,
    input  logic [N_PINS-1:0] db_enable,
    input  logic [CNT_W-1:0]  db_threshold,
    input  logic [N_PINS-1:0] irq_en,
    input  logic [N_PINS-1:0] irq_type,
    input  logic [N_PINS-1:0] irq_pol,
    input  logic [N_PINS-1:0] irq_both,
    input  logic [N_PINS-1:0] irq_clear,
    output logic [N_PINS-1:0] db_gpio_in,
    output logic [N_PINS-1:0] irq_status,
    output logic              irq
);

    logic [N_PINS-1:0] w_db_q;
    logic [N_PINS-1:0] r_db_prev;
    logic [N_PINS-1:0] r_irq_status;
    logic [N_PINS-1:0] w_event;

    for (genvar g = 0; g < N_PINS; g++) begin : g_pin
        gpio_debounce_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .PCLK      (PCLK),
            .PRESETn   (PRESETn),
            .sync_in   (sync_gpio_in[g]),
            .db_en     (db_enable[g]),
            .threshold (db_threshold),
            .db_out    (w_db_q[g])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_event = '0;
        for (int i = 0; i < N_PINS; i++) begin
            w_event[i] = pin_event(irq_type[i], irq_pol[i], irq_both[i],
                                   w_db_q[i], r_db_prev[i]);
        end
    end

    // Set wins over a simultaneous clear; irq_en gates setting as well as irq.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_db_prev    <= '0;
            r_irq_status <= '0;
        end else begin
            r_db_prev    <= w_db_q;
            r_irq_status <= (r_irq_status & ~irq_clear) | (w_event & irq_en);
        end
    end

    assign db_gpio_in = w_db_q;
    assign irq_status = r_irq_status;
    assign irq        = |(r_irq_status & irq_en);

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Directed bench: a cycle-by-cycle vector table for bypass/status behaviour,
// plus hand-written sequences for debounce timing, threshold change and reset.
module tb_gpio_debounce_irq;

    logic        PCLK;
    logic        PRESETn;
    logic [31:0] sync_gpio_in;
    logic [31:0] db_enable;
    logic [7:0]  db_threshold;
    logic [31:0] irq_en;
    logic [31:0] irq_type;
    logic [31:0] irq_pol;
    logic [31:0] irq_both;
    logic [31:0] irq_clear;
    logic [31:0] db_gpio_in;
    logic [31:0] irq_status;
    logic        irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    gpio_debounce_irq #(
        .N_PINS (32),
        .CNT_W  (8)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .sync_gpio_in (sync_gpio_in),
        .db_enable    (db_enable),
        .db_threshold (db_threshold),
        .irq_en       (irq_en),
        .irq_type     (irq_type),
        .irq_pol      (irq_pol),
        .irq_both     (irq_both),
        .irq_clear    (irq_clear),
        .db_gpio_in   (db_gpio_in),
        .irq_status   (irq_status),
        .irq          (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] sync;
        logic [31:0] clr;
        logic [31:0] en;
        logic [31:0] exp_db;
        logic [31:0] exp_st;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic clear_inputs();
        sync_gpio_in = '0;
        db_enable    = '0;
        db_threshold = '0;
        irq_en       = '0;
        irq_type     = '0;
        irq_pol      = '0;
        irq_both     = '0;
        irq_clear    = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        PRESETn = 1'b0;
        tick();
        tick();
        PRESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // sync, clear, irq_en -> db_gpio_in, irq_status, irq (after the edge)
        vecs[0]  = '{32'h00, 32'h00, 32'hA4, 32'h00, 32'h00, 1'b0};
        vecs[1]  = '{32'h20, 32'h00, 32'hA4, 32'h20, 32'h00, 1'b0};
        vecs[2]  = '{32'h20, 32'h00, 32'hA4, 32'h20, 32'h20, 1'b1};
        vecs[3]  = '{32'h00, 32'h20, 32'hA4, 32'h00, 32'h00, 1'b0};
        vecs[4]  = '{32'h00, 32'h00, 32'hA4, 32'h00, 32'h20, 1'b1};
        vecs[5]  = '{32'h00, 32'h20, 32'hA4, 32'h00, 32'h00, 1'b0};
        vecs[6]  = '{32'h80, 32'h00, 32'hA4, 32'h80, 32'h00, 1'b0};
        vecs[7]  = '{32'h80, 32'h00, 32'hA4, 32'h80, 32'h80, 1'b1};
        vecs[8]  = '{32'h80, 32'h80, 32'hA4, 32'h80, 32'h80, 1'b1};
        vecs[9]  = '{32'h80, 32'h80, 32'h24, 32'h80, 32'h00, 1'b0};
        vecs[10] = '{32'h80, 32'h00, 32'hA4, 32'h80, 32'h80, 1'b1};
        vecs[11] = '{32'h84, 32'h00, 32'hA4, 32'h84, 32'h80, 1'b1};
        vecs[12] = '{32'h84, 32'h04, 32'hA4, 32'h84, 32'h84, 1'b1};
        vecs[13] = '{32'h84, 32'h04, 32'hA4, 32'h84, 32'h80, 1'b1};
        vecs[14] = '{32'h04, 32'h00, 32'hA4, 32'h04, 32'h80, 1'b1};
        vecs[15] = '{32'h04, 32'h80, 32'hA4, 32'h04, 32'h00, 1'b0};
        vecs[16] = '{32'h06, 32'h00, 32'hA4, 32'h06, 32'h00, 1'b0};
        vecs[17] = '{32'h06, 32'h00, 32'hA4, 32'h06, 32'h00, 1'b0};
        vecs[18] = '{32'h04, 32'h00, 32'hA4, 32'h04, 32'h00, 1'b0};
        vecs[19] = '{32'h06, 32'h00, 32'hA6, 32'h06, 32'h00, 1'b0};
        vecs[20] = '{32'h06, 32'h00, 32'hA6, 32'h06, 32'h02, 1'b1};
        vecs[21] = '{32'h06, 32'h00, 32'hA4, 32'h06, 32'h02, 1'b0};
        vecs[22] = '{32'h06, 32'h00, 32'hA6, 32'h06, 32'h02, 1'b1};
        vecs[23] = '{32'h06, 32'h02, 32'hA6, 32'h06, 32'h00, 1'b0};

        clear_inputs();
        PRESETn = 1'b0;
        #3;
        check("reset_db", db_gpio_in, 32'h0);
        check("reset_status", irq_status, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_dut();

        // Bypass table: pin1/2 rising edge, pin5 both edges, pin7 level high.
        irq_type = 32'h26;
        irq_pol  = 32'h86;
        irq_both = 32'h20;
        for (int i = 0; i < 24; i++) begin
            sync_gpio_in = vecs[i].sync;
            irq_clear    = vecs[i].clr;
            irq_en       = vecs[i].en;
            tick();
            check($sformatf("vec%0d_db", i), db_gpio_in, vecs[i].exp_db);
            check($sformatf("vec%0d_status", i), irq_status, vecs[i].exp_st);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end

        // T=4 debounce on pins 0 and 3, rising-edge interrupts.
        reset_dut();
        db_threshold = 8'd4;
        db_enable    = 32'h9;
        irq_en       = 32'h9;
        irq_type     = 32'h9;
        irq_pol      = 32'h9;
        sync_gpio_in = 32'h1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("db_hold_edge%0d", k), db_gpio_in, 32'h0);
        end
        tick();
        check("db_commit_edge4", db_gpio_in, 32'h1);
        check("status_not_yet", irq_status, 32'h0);
        tick();
        check("status_edge5", irq_status, 32'h1);
        check("irq_edge5", {31'b0, irq}, 32'h1);
        repeat (5) tick();
        check("db_held", db_gpio_in, 32'h1);

        // Two 3-cycle glitches on pin3 must never commit.
        for (int p = 0; p < 2; p++) begin
            sync_gpio_in = 32'h9;
            repeat (3) tick();
            check($sformatf("glitch%0d_db", p), db_gpio_in, 32'h1);
            sync_gpio_in = 32'h1;
            repeat (2) tick();
        end
        check("glitch_db_final", db_gpio_in, 32'h1);
        check("glitch_status", irq_status, 32'h1);

        // T=200 lowered to 10 at cnt=50 commits on the next edge.
        reset_dut();
        db_threshold = 8'd200;
        db_enable    = 32'h1;
        irq_en       = 32'h1;
        irq_type     = 32'h1;
        irq_pol      = 32'h1;
        sync_gpio_in = 32'h1;
        repeat (50) tick();
        check("thr200_cnt50_db", db_gpio_in, 32'h0);
        db_threshold = 8'd10;
        tick();
        check("thr_lowered_commit", db_gpio_in, 32'h1);
        tick();
        check("thr_lowered_status", irq_status, 32'h1);

        // Reset asserted mid-count clears everything without a clock edge.
        db_threshold = 8'd200;
        sync_gpio_in = 32'h0;
        repeat (5) tick();
        check("midcount_db", db_gpio_in, 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("async_reset_db", db_gpio_in, 32'h0);
        check("async_reset_status", irq_status, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        #2;
        PRESETn = 1'b1;
        repeat (3) tick();
        check("post_reset_db", db_gpio_in, 32'h0);
        check("post_reset_status", irq_status, 32'h0);

        // Threshold 0 behaves as 1: commit at the first edge.
        db_threshold = 8'd0;
        sync_gpio_in = 32'h1;
        tick();
        check("thr0_commit", db_gpio_in, 32'h1);
        tick();
        check("thr0_status", irq_status, 32'h1);
        check("thr0_irq", {31'b0, irq}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
